// File: rtl/pattern_pkg.sv
// Shared defaults and state encoding for the serial/parallel pattern store.
package pattern_pkg;

    // Default geometry: bits per word and number of words.
    localparam int PATTERN_WIDTH = 8;
    localparam int PATTERN_DEPTH = 32;

    // Serial-load sequencer states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

    // Total number of serial shifts that make up one complete load.
    function automatic int total_bits(input int width, input int depth);
        return width * depth;
    endfunction

endpackage

// File: rtl/pattern_row.sv
// One pattern word: synchronous clear, serial shift-in, parallel load, hold.
// Shift wins over load so that a serial transfer is never corrupted.
module pattern_row
    import pattern_pkg::*;
#(
    parameter int WIDTH = PATTERN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             shift_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    // Word storage: clear first, then shift, then parallel load, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], shift_in};
        end else if (load_en) begin
            q <= load_data;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pattern_store.sv
// Pattern store: DEPTH words of WIDTH bits, loadable as one long serial chain
// (word 0 LSB in, word DEPTH-1 MSB out) or word-by-word in parallel.
// A small sequencer counts a full serial load and flags its completion.
module pattern_store
    import pattern_pkg::*;
#(
    parameter int WIDTH = PATTERN_WIDTH,
    parameter int DEPTH = PATTERN_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ssel,
    input  logic                        sen,
    input  logic                        sin,
    input  logic                        rot,
    output logic                        sout,
    input  logic [PTR_W-1:0]            fieldp,
    input  logic [WIDTH-1:0]            field_in,
    input  logic                        field_write,
    output logic [WIDTH-1:0]            field_byte,
    output logic [DEPTH-1:0][WIDTH-1:0] pattern,
    output logic                        load_done,
    output logic                        busy,
    output logic                        ptr_err
);

    localparam int TOTAL = total_bits(WIDTH, DEPTH);
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              shift_s;
    logic              ptr_ok_s;
    logic              write_s;
    logic              bad_write_s;
    logic              bit_in_s;
    load_state_e       state_r;
    logic [CNT_W-1:0]  cnt_r;

    // The serial chain tail is visible directly from storage.
    assign sout = pattern[DEPTH-1][WIDTH-1];

    // Request decode: shift outranks parallel writes; serial mode blocks writes
    always_comb begin
        shift_s     = ssel & sen;
        ptr_ok_s    = (int'(fieldp) < DEPTH);
        write_s     = field_write & ~ssel & ptr_ok_s;
        bad_write_s = field_write & ~ssel & ~ptr_ok_s;
        if (rot) begin
            bit_in_s = sout;
        end else begin
            bit_in_s = sin;
        end
    end

    // Word array: each row takes the previous row's MSB as its serial input
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        logic shift_in_s;
        logic load_en_s;

        if (i == 0) begin : g_head
            assign shift_in_s = bit_in_s;
        end else begin : g_link
            assign shift_in_s = pattern[i-1][WIDTH-1];
        end

        assign load_en_s = write_s & (fieldp == PTR_W'(i));

        pattern_row #(
            .WIDTH(WIDTH)
        ) u_row (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (shift_s),
            .shift_in (shift_in_s),
            .load_en  (load_en_s),
            .load_data(field_in),
            .q        (pattern[i])
        );
    end

    // Registered word read; samples storage before a same-cycle write lands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field_byte <= '0;
        end else if (ptr_ok_s) begin
            field_byte <= pattern[fieldp];
        end else begin
            field_byte <= '0;
        end
    end

    // Load sequencer: counts shifts, flags completion, aborts when ssel drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            ptr_err   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            ptr_err   <= bad_write_s;
            case (state_r)
                IDLE: begin
                    if (shift_s) begin
                        // The shift that starts a load is the first one counted.
                        state_r <= LOAD;
                        busy    <= 1'b1;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                LOAD: begin
                    if (!ssel) begin
                        // Abort: shifted data stays, count restarts.
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                    end else if (sen) begin
                        if (cnt_r == CNT_LAST) begin
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                            cnt_r     <= '0;
                            load_done <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                            busy    <= 1'b1;
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_r <= LOAD;
                        busy    <= 1'b1;
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_store.sv
// Self-checking bench for pattern_store: a 32-word and a 24-word instance
// share all inputs; storage is predicted by a flat shift-register model.
module tb_pattern_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ssel;
    logic        sen;
    logic        sin;
    logic        rot;
    logic        field_write;
    logic [4:0]  fieldp;
    logic [7:0]  field_in;

    logic             sout;
    logic             load_done;
    logic             busy;
    logic             ptr_err;
    logic [7:0]       field_byte;
    logic [31:0][7:0] pattern;

    logic             sout24;
    logic             load_done24;
    logic             busy24;
    logic             ptr_err24;
    logic [7:0]       field_byte24;
    logic [23:0][7:0] pattern24;

    logic [255:0] m32;
    logic [191:0] m24;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fb_q[$];
    logic       sout_q[$];

    always #5 clk = ~clk;

    pattern_store #(.WIDTH(8), .DEPTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .ssel(ssel), .sen(sen), .sin(sin), .rot(rot),
        .sout(sout), .fieldp(fieldp), .field_in(field_in), .field_write(field_write),
        .field_byte(field_byte), .pattern(pattern), .load_done(load_done),
        .busy(busy), .ptr_err(ptr_err)
    );

    pattern_store #(.WIDTH(8), .DEPTH(24)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .ssel(ssel), .sen(sen), .sin(sin), .rot(rot),
        .sout(sout24), .fieldp(fieldp), .field_in(field_in), .field_write(field_write),
        .field_byte(field_byte24), .pattern(pattern24), .load_done(load_done24),
        .busy(busy24), .ptr_err(ptr_err24)
    );

    task automatic idle_inputs();
        rst_n = 1'b1; ssel = 1'b0; sen = 1'b0; sin = 1'b0; rot = 1'b0;
        field_write = 1'b0; fieldp = 5'd0; field_in = 8'h00;
    endtask

    // Predict the storage effect of the coming edge, then advance one cycle.
    task automatic step();
        logic b32;
        logic b24;
        b32 = rot ? m32[255] : sin;
        b24 = rot ? m24[191] : sin;
        if (!rst_n) begin
            m32 = '0;
            m24 = '0;
        end else if (ssel && sen) begin
            m32 = {m32[254:0], b32};
            m24 = {m24[190:0], b24};
        end else if (field_write && !ssel) begin
            m32[int'(fieldp)*8 +: 8] = field_in;
            if (fieldp < 5'd24) m24[int'(fieldp)*8 +: 8] = field_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; ssel = 1'b1; sen = 1'b1; sin = 1'b1; field_write = 1'b1;
        step();
        n_cmp++; if (pattern !== 256'd0) begin n_bad++; $display("FAIL reset_pattern got %h expected 0", pattern); end
        n_cmp++; if (pattern24 !== 192'd0) begin n_bad++; $display("FAIL reset_pattern24 got %h expected 0", pattern24); end
        n_cmp++; if (field_byte !== 8'h00) begin n_bad++; $display("FAIL reset_field_byte got %h expected 00", field_byte); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done got %b expected 0", load_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_cmp++; if (ptr_err !== 1'b0) begin n_bad++; $display("FAIL reset_ptr_err got %b expected 0", ptr_err); end
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL reset_sout got %b expected 0", sout); end
        idle_inputs();
    endtask

    task automatic test_full_load();
        int pulses;
        pulses = 0;
        do_reset();
        ssel = 1'b1; sen = 1'b1; sin = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (load_done === 1'b1) pulses++;
            n_cmp++; if (busy !== ((k < 256) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL full_busy shift %0d got %b", k, busy); end
            n_cmp++; if (load_done !== ((k == 256) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL full_load_done shift %0d got %b", k, load_done); end
        end
        idle_inputs();
        step();
        n_cmp++; if (pattern !== {256{1'b1}}) begin n_bad++; $display("FAIL full_pattern got %h expected all ones", pattern); end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL full_pulse_count got %0d expected 1", pulses); end
        n_cmp++; if (busy !== 1'b0 || load_done !== 1'b0) begin n_bad++; $display("FAIL full_after got busy=%b done=%b expected 0/0", busy, load_done); end
    endtask

    task automatic test_field_rw();
        logic [7:0] got;
        do_reset();
        fieldp = 5'd5; field_in = 8'hA5; field_write = 1'b1;
        fb_q.push_back(8'h00);
        step();
        got = fb_q.pop_front();
        n_cmp++; if (field_byte !== got) begin n_bad++; $display("FAIL rw_read_before_write got %h expected %h", field_byte, got); end
        field_write = 1'b0;
        fb_q.push_back(8'hA5);
        step();
        got = fb_q.pop_front();
        n_cmp++; if (field_byte !== got) begin n_bad++; $display("FAIL rw_readback got %h expected %h", field_byte, got); end
        n_cmp++; if (pattern[5] !== 8'hA5) begin n_bad++; $display("FAIL rw_word5 got %h expected a5", pattern[5]); end
        n_cmp++; if (pattern !== m32) begin n_bad++; $display("FAIL rw_others got %h expected %h", pattern, m32); end
        n_cmp++; if (ptr_err !== 1'b0) begin n_bad++; $display("FAIL rw_ptr_err got %b expected 0", ptr_err); end
        idle_inputs();
    endtask

    task automatic test_rotate();
        logic [255:0] snap;
        logic         exp_bit;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            fieldp = 5'(i); field_in = 8'(i); field_write = 1'b1;
            step();
            n_cmp++; if (ptr_err24 !== ((i >= 24) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL rot_ptr_err24 word %0d got %b", i, ptr_err24); end
        end
        field_write = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (pattern[i] !== 8'(i)) begin n_bad++; $display("FAIL rot_preload word %0d got %h", i, pattern[i]); end
        end
        snap = m32;
        for (int k = 0; k < 256; k++) sout_q.push_back(snap[255-k]);
        ssel = 1'b1; sen = 1'b1; rot = 1'b1; sin = 1'b0;
        for (int k = 0; k < 256; k++) begin
            exp_bit = sout_q.pop_front();
            n_cmp++; if (sout !== exp_bit) begin n_bad++; $display("FAIL rot_sout bit %0d got %b expected %b", k, sout, exp_bit); end
            step();
        end
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL rot_load_done got %b expected 1", load_done); end
        n_cmp++; if (pattern !== snap) begin n_bad++; $display("FAIL rot_contents got %h expected %h", pattern, snap); end
        n_cmp++; if (pattern24 !== m24) begin n_bad++; $display("FAIL rot_contents24 got %h expected %h", pattern24, m24); end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        ssel = 1'b1; sen = 1'b1; sin = 1'b1; field_write = 1'b1; fieldp = 5'd0; field_in = 8'h3C;
        step();
        n_cmp++; if (pattern[0] === 8'h3C) begin n_bad++; $display("FAIL prio_no_write got %h expected not 3c", pattern[0]); end
        n_cmp++; if (pattern[0] !== 8'h01) begin n_bad++; $display("FAIL prio_shift got %h expected 01", pattern[0]); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL prio_busy got %b expected 1", busy); end
        sen = 1'b0;
        step();
        n_cmp++; if (pattern !== m32) begin n_bad++; $display("FAIL hold_pattern got %h expected %h", pattern, m32); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy got %b expected 1", busy); end
        ssel = 1'b0; field_write = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || load_done !== 1'b0) begin n_bad++; $display("FAIL abort got busy=%b done=%b expected 0/0", busy, load_done); end
        n_cmp++; if (pattern[0] !== 8'h01) begin n_bad++; $display("FAIL abort_keep got %h expected 01", pattern[0]); end
        idle_inputs();
    endtask

    task automatic test_ptr_err();
        do_reset();
        fieldp = 5'd30; field_in = 8'h77; field_write = 1'b1;
        step();
        n_cmp++; if (ptr_err24 !== 1'b1) begin n_bad++; $display("FAIL ptr_err24_pulse got %b expected 1", ptr_err24); end
        n_cmp++; if (pattern24 !== 192'd0) begin n_bad++; $display("FAIL ptr_err24_storage got %h expected 0", pattern24); end
        n_cmp++; if (ptr_err !== 1'b0) begin n_bad++; $display("FAIL ptr_err32 got %b expected 0", ptr_err); end
        n_cmp++; if (pattern[30] !== 8'h77) begin n_bad++; $display("FAIL ptr_word30 got %h expected 77", pattern[30]); end
        field_write = 1'b0;
        step();
        n_cmp++; if (ptr_err24 !== 1'b0) begin n_bad++; $display("FAIL ptr_err24_single got %b expected 0", ptr_err24); end
        idle_inputs();
    endtask

    task automatic test_reset_midload();
        int pulses;
        pulses = 0;
        do_reset();
        ssel = 1'b1; sen = 1'b1;
        for (int k = 0; k < 100; k++) begin
            sin = 1'($urandom_range(0, 1));
            step();
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b expected 1", busy); end
        rst_n = 1'b0; field_write = 1'b1; field_in = 8'hFF; sin = 1'b1;
        step();
        n_cmp++; if (pattern !== 256'd0) begin n_bad++; $display("FAIL mid_reset_pattern got %h expected 0", pattern); end
        n_cmp++; if (busy !== 1'b0 || load_done !== 1'b0 || field_byte !== 8'h00) begin n_bad++; $display("FAIL mid_reset_ctl got busy=%b done=%b fb=%h expected 0", busy, load_done, field_byte); end
        rst_n = 1'b1; field_write = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            sin = 1'($urandom_range(0, 1));
            step();
            if (load_done === 1'b1) pulses++;
            n_cmp++; if (load_done !== ((k == 256) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL mid_reload_done shift %0d got %b", k, load_done); end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL mid_pulse_count got %0d expected 1", pulses); end
        n_cmp++; if (pattern !== m32) begin n_bad++; $display("FAIL mid_reload_pattern got %h expected %h", pattern, m32); end
        idle_inputs();
    endtask

    initial begin
        m32 = '0;
        m24 = '0;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_full_load();
        test_field_rw();
        test_rotate();
        test_priority();
        test_ptr_err();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
